// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART echo-path FIFO.
//   UART_DATA_W  : default byte width, matching the UART core default.
//   uart_check_e : UART parity/check encodings (NONE=0, ODD=1, EVEN=2).
//   addr_w()     : address width for a given power-of-two FIFO depth.
package uart_tx_fifo_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [1:0] {
    CHK_NONE = 2'd0,
    CHK_ODD  = 2'd1,
    CHK_EVEN = 2'd2
  } uart_check_e;

  function automatic int unsigned addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port RAM, P_DEPTH x P_DATA_WIDTH, distributed-RAM friendly.
//   i_clk   : write clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address (asynchronous read)
//   o_rdata : data at i_raddr
module uart_fifo_mem #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_DEPTH      = 16
) (
  input  logic                       i_clk,
  input  logic                       i_we,
  input  logic [$clog2(P_DEPTH)-1:0] i_waddr,
  input  logic [P_DATA_WIDTH-1:0]    i_wdata,
  input  logic [$clog2(P_DEPTH)-1:0] i_raddr,
  output logic [P_DATA_WIDTH-1:0]    o_rdata
);

  // Contents are deliberately never reset so the array maps to LUT RAM.
  logic [P_DATA_WIDTH-1:0] mem_q [P_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the UART receive strobe and the transmit handshake
// (echo/loopback path). Received bytes cannot be back-pressured, so bytes
// arriving while full are dropped and counted.
//   i_clk, i_rst          : clock, async active-high reset
//   i_rx_data, i_rx_valid : received byte strobe (no ready)
//   o_tx_data, o_tx_valid : byte offered to transmitter
//   i_tx_ready            : transmitter accept
//   o_count               : occupancy 0..P_DEPTH
//   o_full, o_empty       : occupancy flags
//   o_overflow            : sticky drop flag
//   o_drop_cnt            : saturating dropped-byte count
//   i_clr_ovf             : synchronous clear of o_overflow/o_drop_cnt
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int P_DATA_WIDTH     = UART_DATA_W,
  parameter int P_DEPTH          = 16,
  parameter int P_DROP_CNT_WIDTH = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [P_DATA_WIDTH-1:0]       i_rx_data,
  input  logic                          i_rx_valid,
  output logic [P_DATA_WIDTH-1:0]       o_tx_data,
  output logic                          o_tx_valid,
  input  logic                          i_tx_ready,
  output logic [$clog2(P_DEPTH):0]      o_count,
  output logic                          o_full,
  output logic                          o_empty,
  output logic                          o_overflow,
  output logic [P_DROP_CNT_WIDTH-1:0]   o_drop_cnt,
  input  logic                          i_clr_ovf
);

  localparam int AW = addr_w(P_DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               count_q, count_d;
  logic                        ovf_q, ovf_d;
  logic [P_DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic [P_DATA_WIDTH-1:0]     rdata;
  logic                        full, empty, push, pop, drop;

  assign full  = (count_q == CW'(P_DEPTH));
  assign empty = (count_q == '0);

  // Pop depends only on registered state plus ready; a full FIFO can
  // still accept a byte when a slot is freed in the same cycle.
  assign pop  = !empty && i_tx_ready;
  assign push = i_rx_valid && (!full || pop);
  assign drop = i_rx_valid && !push;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as a clear wins, restarting the count at 1.
    if (drop) begin
      ovf_d = 1'b1;
      if (i_clr_ovf) begin
        drop_cnt_d = P_DROP_CNT_WIDTH'(1);
      end else if (drop_cnt_q != {P_DROP_CNT_WIDTH{1'b1}}) begin
        drop_cnt_d = drop_cnt_q + P_DROP_CNT_WIDTH'(1);
      end
    end else if (i_clr_ovf) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  uart_fifo_mem #(
    .P_DATA_WIDTH (P_DATA_WIDTH),
    .P_DEPTH      (P_DEPTH)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (push),
    .i_waddr (wr_ptr_q),
    .i_wdata (i_rx_data),
    .i_raddr (rd_ptr_q),
    .o_rdata (rdata)
  );

  // Unreset RAM contents are masked so the offered byte reads 0 when empty.
  assign o_tx_data  = empty ? '0 : rdata;
  assign o_tx_valid = !empty;
  assign o_count    = count_q;
  assign o_full     = full;
  assign o_empty    = empty;
  assign o_overflow = ovf_q;
  assign o_drop_cnt = drop_cnt_q;

endmodule
